// File: rtl/fifo_unpacker.sv
// Read-side adapter for a show-ahead FIFO. Each wide word is split into
// IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream, least-significant slice first.
module fifo_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_rd_en_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_ratio
            $error("fifo_unpacker: IN_WIDTH must be an integer multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH-1:0] sreg;
    logic [CNT_W-1:0]    cnt;
    logic                valid_q;
    logic                accept;
    logic                last;
    logic                load;

    assign accept = valid_q && out_ready_i;
    assign last   = (cnt == LAST_CNT);

    // Reset gates the pop so the FIFO head never advances while the block is held in reset.
    assign load = rst_ni && !fifo_empty_i && (!valid_q || (accept && last));

    assign fifo_rd_en_o = load;
    assign out_data_o   = sreg[OUT_WIDTH-1:0];
    assign out_valid_o  = valid_q;
    assign out_last_o   = valid_q && last;
    assign busy_o       = valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg    <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            sreg    <= fifo_data_i;
            cnt     <= '0;
            valid_q <= 1'b1;
        end else if (accept && !last) begin
            sreg <= sreg >> OUT_WIDTH;
            cnt  <= cnt + CNT_W'(1);
        end else if (accept) begin
            // Final beat taken with nothing waiting upstream: go idle.
            valid_q <= 1'b0;
            cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker (32->8): cycle-by-cycle vector table plus
// hand-written reset sequences driven from a small show-ahead FIFO model.
module tb_fifo_unpacker;

    typedef struct {
        logic        empty;
        logic [31:0] data;
        logic        ready;
        logic        exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic        chk_data;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int assert_count = 0;
    int fail_count   = 0;
    vec_t vecs[$];
    logic [31:0] model_q[$];

    fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_en_o (fifo_rd_en),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic [31:0] d, input logic r,
                                input logic rd, input logic v, input logic [7:0] od,
                                input logic l, input logic cd);
        vec_t t;
        t.empty = e; t.data = d; t.ready = r; t.exp_rd = rd;
        t.exp_valid = v; t.exp_data = od; t.exp_last = l; t.chk_data = cd;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs at posedge+1, checks mid-cycle, returns at the next posedge+1.
    task automatic applyStimulus(input vec_t v, input int idx);
        fifo_empty = v.empty;
        fifo_data  = v.data;
        out_ready  = v.ready;
        #3;
        checkOutput($sformatf("rd_en[%0d]", idx), 32'(fifo_rd_en), 32'(v.exp_rd));
        checkOutput($sformatf("valid[%0d]", idx), 32'(out_valid), 32'(v.exp_valid));
        checkOutput($sformatf("busy[%0d]", idx), 32'(busy), 32'(v.exp_valid));
        checkOutput($sformatf("last[%0d]", idx), 32'(out_last), 32'(v.exp_last));
        if (v.chk_data)
            checkOutput($sformatf("data[%0d]", idx), 32'(out_data), 32'(v.exp_data));
        @(posedge clk);
        #1;
    endtask

    task automatic driveFromModel();
        fifo_empty = (model_q.size() == 0);
        fifo_data  = (model_q.size() == 0) ? 32'h0 : model_q[0];
    endtask

    initial begin
        logic        rd_seen;
        logic        found;
        logic [7:0]  beats[$];
        logic        lasts[$];
        logic [7:0]  exp_beats[4];

        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 32'hDDCCBBAA;
        out_ready  = 1'b1;

        // Single word, then two words back to back.
        vecs.push_back(mk(0, 32'hDDCCBBAA, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'hAA, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'hBB, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'hCC, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'hDD, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 32'h03020100, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 32'h07060504, 1, 0, 1, 8'h00, 0, 1));
        vecs.push_back(mk(0, 32'h07060504, 1, 0, 1, 8'h01, 0, 1));
        vecs.push_back(mk(0, 32'h07060504, 1, 0, 1, 8'h02, 0, 1));
        vecs.push_back(mk(0, 32'h07060504, 1, 1, 1, 8'h03, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h04, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h05, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h06, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h07, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 0, 8'h00, 0, 0));
        // Backpressure on BB with a word waiting, then late arrival at the last beat.
        vecs.push_back(mk(0, 32'hDDCCBBAA, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'hAA, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 0, 0, 1, 8'hBB, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 0, 0, 1, 8'hBB, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 0, 0, 1, 8'hBB, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 1, 0, 1, 8'hBB, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 1, 0, 1, 8'hCC, 0, 1));
        vecs.push_back(mk(0, 32'h44332211, 1, 1, 1, 8'hDD, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h11, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h22, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h33, 0, 1));
        vecs.push_back(mk(0, 32'h88776655, 1, 1, 1, 8'h44, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h55, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h66, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h77, 0, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 1, 8'h88, 1, 1));
        vecs.push_back(mk(1, 32'h0,        1, 0, 0, 8'h00, 0, 0));

        $display("[TB] reset with non-empty FIFO");
        repeat (2) @(posedge clk);
        #4;
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'h0);
        checkOutput("reset_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_data", 32'(out_data), 32'h0);
        checkOutput("reset_last", 32'(out_last), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] vector table, %0d cycles", vecs.size());
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        $display("[TB] asynchronous reset while CC is presented");
        model_q = '{32'hDDCCBBAA, 32'h0D0C0B0A};
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            driveFromModel();
            #3;
            if (out_valid && out_data == 8'hCC) begin
                found = 1'b1;
            end else begin
                rd_seen = fifo_rd_en;
                @(posedge clk);
                #1;
                if (rd_seen && model_q.size() > 0) void'(model_q.pop_front());
            end
        end
        checkOutput("reach_cc", 32'(found), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(out_valid), 32'h0);
        checkOutput("async_data", 32'(out_data), 32'h0);
        checkOutput("async_last", 32'(out_last), 32'h0);
        checkOutput("async_rd_en", 32'(fifo_rd_en), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("held_rd_en", 32'(fifo_rd_en), 32'h0);
        rst_n = 1'b1;

        for (int c = 0; c < 12 && beats.size() < 4; c++) begin
            driveFromModel();
            #3;
            if (c == 0) checkOutput("release_rd_en", 32'(fifo_rd_en), 32'h1);
            if (out_valid) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
            end
            rd_seen = fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd_seen && model_q.size() > 0) void'(model_q.pop_front());
        end
        checkOutput("post_reset_beats", 32'(beats.size()), 32'd4);
        exp_beats = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checkOutput($sformatf("post_reset_data[%0d]", i), 32'(beats[i]), 32'(exp_beats[i]));
            checkOutput($sformatf("post_reset_last[%0d]", i), 32'(lasts[i]), 32'(i == 3));
        end
        checkOutput("model_drained", 32'(model_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
